pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the next-generation lvm core. It replaces the fixed 16-bit PC/jump-condition pair with configurable address and data widths, a branch-condition evaluator, and a hardware return-address stack for CALL/RET. It sits between the instruction decoder and the instruction-memory address port, and advances one instruction per `clk` unless stalled.

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/ret_stack.sv | 67 ++++++
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the pc_sequencer block: operation codes and branch-mask
// bit positions.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_INC  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BR   = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_e;

  localparam int COND_LT = 2;
  localparam int COND_EQ = 1;
  localparam int COND_GT = 0;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with a saturating depth counter; with WRAP_EN set it acts
// as a circular buffer whose oldest entry is overwritten by a push when full.
module ret_stack #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter bit WRAP_EN     = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic [ADDR_W-1:0]                i_data,
  output logic [ADDR_W-1:0]                o_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0] o_depth,
  output logic                             o_full,
  output logic                             o_empty
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = $clog2(STACK_DEPTH+1);
  localparam logic [PTR_W-1:0]   LAST_IDX  = PTR_W'(STACK_DEPTH - 1);
  localparam logic [DEPTH_W-1:0] FULL_CNT  = DEPTH_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]  r_mem [STACK_DEPTH];
  logic [PTR_W-1:0]   r_ptr;    // next free slot; top lives one below it
  logic [DEPTH_W-1:0] r_count;

  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_ptr_inc;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_depth   = r_count;
  assign w_top_idx = (r_ptr == '0) ? LAST_IDX : r_ptr - 1'b1;
  assign w_ptr_inc = (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
  assign o_top     = r_mem[w_top_idx];
  assign w_do_push = i_push && (!o_full || WRAP_EN);
  assign w_do_pop  = i_pop && !o_empty && !i_push;

  // NOTE: the entry storage carries no reset; only the pointer and count define
  // which entries are valid, so resetting the array would only add wiring.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_ptr] <= i_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      r_ptr <= w_ptr_inc;
      if (!o_full) begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_do_pop) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch evaluation and a CALL/RET return stack.
// Define PC_SEQ_WRAP_STACK_EN to make the return stack circular on overflow.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               ADDR_W      = 16,
  parameter int               DATA_W      = 16,
  parameter int               STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic [2:0]                       op,
  input  logic [2:0]                       cond,
  input  logic [DATA_W-1:0]                val,
  input  logic [ADDR_W-1:0]                target,
  output logic [ADDR_W-1:0]                pc,
  output logic                             taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             ovf,
  output logic                             unf
);

`ifdef PC_SEQ_WRAP_STACK_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] r_pc;
  logic              r_taken;
  logic              r_ovf;
  logic              r_unf;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_taken_next;
  logic              w_push_req;
  logic              w_pop_req;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [2:0]        w_flags;
  logic              w_hit;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;

  // Branch evaluator: val is signed, so the MSB alone decides "less than zero".
  assign w_pc_inc         = r_pc + 1'b1;
  assign w_flags[COND_LT] = val[DATA_W-1];
  assign w_flags[COND_EQ] = (val == '0);
  assign w_flags[COND_GT] = !val[DATA_W-1] && (val != '0);
  assign w_hit            = |(cond & w_flags);

  // NOTE: every signal is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_pc_next    = w_pc_inc;
    w_taken_next = 1'b0;
    w_push_req   = 1'b0;
    w_pop_req    = 1'b0;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    case (op_e'(op))
      OP_JMP: begin
        w_pc_next    = target;
        w_taken_next = 1'b1;
      end
      OP_BR: begin
        if (w_hit) begin
          w_pc_next    = target;
          w_taken_next = 1'b1;
        end
      end
      OP_CALL: begin
        if (!w_full || WRAP_EN) begin
          w_push_req   = 1'b1;
          w_pc_next    = target;
          w_taken_next = 1'b1;
        end else begin
          w_ovf_set = 1'b1;
        end
      end
      OP_RET: begin
        if (!w_empty) begin
          w_pop_req    = 1'b1;
          w_pc_next    = w_top;
          w_taken_next = 1'b1;
        end else begin
          w_unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_VEC;
      r_taken <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (stall) begin
      r_taken <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_taken <= w_taken_next;
      r_ovf   <= r_ovf | w_ovf_set;
      r_unf   <= r_unf | w_unf_set;
    end
  end

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .WRAP_EN     (WRAP_EN)
  ) u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req && !stall),
    .i_pop   (w_pop_req && !stall),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_depth (depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign pc    = r_pc;
  assign taken = r_taken;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (RESET_VEC = 0x0100, STACK_DEPTH = 2); the
// overflow expectations follow PC_SEQ_WRAP_STACK_EN when it is defined.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  op;
  logic [2:0]  cond;
  logic [15:0] val;
  logic [15:0] target;
  logic [15:0] pc;
  logic        taken;
  logic [1:0]  depth;
  logic        ovf;
  logic        unf;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PC_SEQ_WRAP_STACK_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  pc_sequencer #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .STACK_DEPTH (2),
    .RESET_VEC   (16'h0100)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .op     (op),
    .cond   (cond),
    .val    (val),
    .target (target),
    .pc     (pc),
    .taken  (taken),
    .depth  (depth),
    .ovf    (ovf),
    .unf    (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one operation on the falling edge and sample 1 ns after the next rising edge.
  task automatic step(input logic [2:0] t_op, input logic [15:0] t_target,
                      input logic [2:0] t_cond = 3'b000, input logic [15:0] t_val = 16'h0,
                      input logic t_stall = 1'b0, input logic t_reset = 1'b0);
    @(negedge clk);
    op     = t_op;
    target = t_target;
    cond   = t_cond;
    val    = t_val;
    stall  = t_stall;
    reset  = t_reset;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [15:0] e_pc, input logic e_taken,
                              input logic [1:0] e_depth);
    check({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check({tag, ".taken"}, 32'(taken), 32'(e_taken));
    check({tag, ".depth"}, 32'(depth), 32'(e_depth));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; op = OP_INC; cond = '0; val = '0; target = '0;

    step(OP_JMP, 16'h5555, 3'b000, 16'h0, 1'b0, 1'b1);
    expect_state("reset", 16'h0100, 1'b0, 2'd0);
    check("reset.ovf", 32'(ovf), 32'd0);
    check("reset.unf", 32'(unf), 32'd0);

    step(OP_INC, 16'h0);  expect_state("inc1", 16'h0101, 1'b0, 2'd0);
    step(OP_INC, 16'h0);  expect_state("inc2", 16'h0102, 1'b0, 2'd0);
    step(3'd7,   16'h0);  expect_state("inc_op7", 16'h0103, 1'b0, 2'd0);

    step(OP_BR, 16'h0040, 3'b010, 16'h0000); expect_state("br_eq", 16'h0040, 1'b1, 2'd0);
    step(OP_BR, 16'h0080, 3'b001, 16'hFFFB); expect_state("br_gt_neg", 16'h0041, 1'b0, 2'd0);
    step(OP_BR, 16'h0080, 3'b100, 16'hFFFB); expect_state("br_lt_neg", 16'h0080, 1'b1, 2'd0);
    step(OP_BR, 16'h0055, 3'b000, 16'h0000); expect_state("br_never", 16'h0081, 1'b0, 2'd0);
    step(OP_BR, 16'h0055, 3'b101, 16'h0000); expect_state("br_zero_miss", 16'h0082, 1'b0, 2'd0);
    step(OP_BR, 16'h0010, 3'b111, 16'h0045); expect_state("br_always", 16'h0010, 1'b1, 2'd0);

    step(OP_CALL, 16'h0200); expect_state("call1", 16'h0200, 1'b1, 2'd1);
    step(OP_CALL, 16'h0300); expect_state("call2", 16'h0300, 1'b1, 2'd2);
    step(OP_RET,  16'h0);    expect_state("ret1", 16'h0201, 1'b1, 2'd1);
    step(OP_RET,  16'h0);    expect_state("ret2", 16'h0011, 1'b1, 2'd0);

    step(OP_CALL, 16'h0500); expect_state("call_b2b", 16'h0500, 1'b1, 2'd1);
    step(OP_RET,  16'h0);    expect_state("ret_b2b", 16'h0012, 1'b1, 2'd0);

    step(OP_JMP,  16'h0010); expect_state("jmp", 16'h0010, 1'b1, 2'd0);
    step(OP_CALL, 16'h0020); expect_state("chain1", 16'h0020, 1'b1, 2'd1);
    step(OP_CALL, 16'h0030); expect_state("chain2", 16'h0030, 1'b1, 2'd2);
    step(OP_CALL, 16'h0040);
    if (WRAP) expect_state("chain3_wrap", 16'h0040, 1'b1, 2'd2);
    else      expect_state("chain3_ovf", 16'h0031, 1'b0, 2'd2);
    check("ovf_after_third_call", 32'(ovf), WRAP ? 32'd0 : 32'd1);
    check("unf_before_ret", 32'(unf), 32'd0);

    step(OP_RET, 16'h0);
    expect_state("chain_ret1", WRAP ? 16'h0031 : 16'h0021, 1'b1, 2'd1);
    step(OP_RET, 16'h0);
    expect_state("chain_ret2", WRAP ? 16'h0021 : 16'h0011, 1'b1, 2'd0);
    step(OP_RET, 16'h0);
    expect_state("ret_unf", WRAP ? 16'h0022 : 16'h0012, 1'b0, 2'd0);
    check("unf_set", 32'(unf), 32'd1);

    step(OP_INC, 16'h0);
    step(OP_JMP, 16'hFFFF);  expect_state("jmp_top", 16'hFFFF, 1'b1, 2'd0);
    step(OP_JMP, 16'h1234, 3'b000, 16'h0, 1'b1);
    expect_state("stall_jmp", 16'hFFFF, 1'b0, 2'd0);
    step(OP_INC, 16'h0);     expect_state("pc_wrap", 16'h0000, 1'b0, 2'd0);
    check("ovf_sticky", 32'(ovf), WRAP ? 32'd0 : 32'd1);
    check("unf_sticky", 32'(unf), 32'd1);

    step(OP_CALL, 16'h0700); expect_state("call_pre_stall", 16'h0700, 1'b1, 2'd1);
    step(OP_RET, 16'h0, 3'b000, 16'h0, 1'b1);
    expect_state("stall_ret", 16'h0700, 1'b0, 2'd1);

    step(OP_JMP, 16'h4321, 3'b000, 16'h0, 1'b1, 1'b1);
    expect_state("reset_stall", 16'h0100, 1'b0, 2'd0);
    check("reset_stall.ovf", 32'(ovf), 32'd0);
    check("reset_stall.unf", 32'(unf), 32'd0);

    step(OP_RET, 16'h0);     expect_state("ret_after_reset", 16'h0101, 1'b0, 2'd0);
    check("unf_after_reset", 32'(unf), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
